// File: rtl/tank_projectiles.sv
// Projectile engine for the tank game: owns a small pool of bullet slots,
// spawns bullets on fire requests, advances them once per frame, retires them
// at the screen edge and reports whether the current pixel lies on a bullet.
module tank_projectiles #(
  parameter int NUM_BULLETS = 4,
  parameter int SIZE        = 4,
  parameter int STEP        = 4,
  parameter int COOLDOWN    = 15,
  parameter int TANK_W      = 50,
  parameter int TANK_H      = 50,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       is_shooting,
  input  logic [2:0] tank_dir,
  input  logic [9:0] tank_X,
  input  logic [9:0] tank_Y,
  output logic       is_bullet,
  output logic       fire_ack,
  output logic [2:0] bullet_count
);

  localparam int IDXW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b100;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b010;

  // All geometry is done in 11 bits so sums past the 10-bit screen range do
  // not wrap back onto the screen.
  localparam logic [10:0] SPAWN_DX   = 11'(TANK_W / 2 - SIZE / 2);
  localparam logic [10:0] SPAWN_DY   = 11'(TANK_H / 2 - SIZE / 2);
  localparam logic [10:0] SIZE_M1    = 11'(SIZE - 1);
  localparam logic [10:0] STEP_11    = 11'(STEP);
  localparam logic [10:0] REACH      = 11'(SIZE - 1 + STEP);
  localparam logic [10:0] X_MAX_11   = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_11   = 11'(Y_MAX);
  localparam logic [4:0]  CD_LOAD    = 5'(COOLDOWN);

  // Slot state and its next-state copies
  logic [NUM_BULLETS-1:0] active, active_nxt;
  logic [9:0]             bx [NUM_BULLETS];
  logic [9:0]             by [NUM_BULLETS];
  logic [2:0]             dir [NUM_BULLETS];
  logic [9:0]             bx_nxt [NUM_BULLETS];
  logic [9:0]             by_nxt [NUM_BULLETS];
  logic [2:0]             dir_nxt [NUM_BULLETS];

  logic [4:0]  cooldown, cooldown_nxt;
  logic        frame_r, frame_d, tick;
  logic        free_found;
  logic [IDXW-1:0] free_idx;
  logic [10:0] sx, sy;
  logic        dir_legal, accept;
  logic [2:0]  count_nxt;

  // Lowest-indexed free slot, judged on registered active only
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  // Spawn point and the accept decision for this cycle's fire request
  always_comb begin
    sx        = {1'b0, tank_X} + SPAWN_DX;
    sy        = {1'b0, tank_Y} + SPAWN_DY;
    dir_legal = (tank_dir == DIR_UP) || (tank_dir == DIR_DOWN) ||
                (tank_dir == DIR_LEFT) || (tank_dir == DIR_RIGHT);
    accept    = is_shooting && (cooldown == 5'd0) && free_found && dir_legal &&
                (sx + SIZE_M1 <= X_MAX_11) && (sy + SIZE_M1 <= Y_MAX_11);
  end

  // Next slot state: movement/retirement on tick, then a spawn on accept
  always_comb begin
    // NOTE: blocking assignments in combinational logic, so later lines in
    // this block see the updated values (the spawn overrides the tick path).
    active_nxt   = active;
    bx_nxt       = bx;
    by_nxt       = by;
    dir_nxt      = dir;
    cooldown_nxt = cooldown;
    count_nxt    = '0;
    if (tick) begin
      if (cooldown != 5'd0) cooldown_nxt = cooldown - 5'd1;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (active[i]) begin
          case (dir[i])
            DIR_UP:
              if ({1'b0, by[i]} < STEP_11) active_nxt[i] = 1'b0;
              else by_nxt[i] = by[i] - 10'(STEP);
            DIR_DOWN:
              if ({1'b0, by[i]} + REACH > Y_MAX_11) active_nxt[i] = 1'b0;
              else by_nxt[i] = by[i] + 10'(STEP);
            DIR_LEFT:
              if ({1'b0, bx[i]} < STEP_11) active_nxt[i] = 1'b0;
              else bx_nxt[i] = bx[i] - 10'(STEP);
            DIR_RIGHT:
              if ({1'b0, bx[i]} + REACH > X_MAX_11) active_nxt[i] = 1'b0;
              else bx_nxt[i] = bx[i] + 10'(STEP);
            default: ;
          endcase
        end
      end
    end
    if (accept) begin
      active_nxt[free_idx] = 1'b1;
      bx_nxt[free_idx]     = sx[9:0];
      by_nxt[free_idx]     = sy[9:0];
      dir_nxt[free_idx]    = tank_dir;
      cooldown_nxt         = CD_LOAD;
    end
    for (int i = 0; i < NUM_BULLETS; i++) count_nxt = count_nxt + 3'(active_nxt[i]);
  end

  // State registers, frame-edge detector and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_r      <= 1'b0;
      frame_d      <= 1'b0;
      tick         <= 1'b0;
      active       <= '0;
      cooldown     <= '0;
      fire_ack     <= 1'b0;
      bullet_count <= '0;
      // NOTE: the slot arrays are plain flops, not RAM, so they can and do
      // take a defined reset value.
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx[i]  <= '0;
        by[i]  <= '0;
        dir[i] <= '0;
      end
    end else begin
      frame_r      <= frame_clk;
      frame_d      <= frame_r;
      tick         <= frame_r & ~frame_d;
      active       <= active_nxt;
      bx           <= bx_nxt;
      by           <= by_nxt;
      dir          <= dir_nxt;
      cooldown     <= cooldown_nxt;
      fire_ack     <= accept;
      bullet_count <= count_nxt;
    end
  end

  // Pixel hit test over all live bullets
  always_comb begin
    is_bullet = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active[i] &&
          ({1'b0, DrawX} >= {1'b0, bx[i]}) && ({1'b0, DrawX} <= {1'b0, bx[i]} + SIZE_M1) &&
          ({1'b0, DrawY} >= {1'b0, by[i]}) && ({1'b0, DrawY} <= {1'b0, by[i]} + SIZE_M1))
        is_bullet = 1'b1;
    end
  end

endmodule

// File: tb/tb_tank_projectiles.sv
// Self-checking bench for tank_projectiles: directed scenarios, a pixel
// vector table, and random fire/tick traffic against a slot-level model.
module tb_tank_projectiles;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       is_shooting = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, tank_X = '0, tank_Y = '0;
  logic [2:0] tank_dir = '0;
  logic       is_bullet, fire_ack, is_bullet_nc, fire_ack_nc;
  logic [2:0] bullet_count, bullet_count_nc;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  tank_projectiles dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .is_shooting(is_shooting), .tank_dir(tank_dir), .tank_X(tank_X), .tank_Y(tank_Y),
    .is_bullet(is_bullet), .fire_ack(fire_ack), .bullet_count(bullet_count)
  );

  // Same design with the cooldown disabled, used for pool-capacity tests
  tank_projectiles #(.COOLDOWN(0)) dut_nc (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .is_shooting(is_shooting), .tank_dir(tank_dir), .tank_X(tank_X), .tank_Y(tank_Y),
    .is_bullet(is_bullet_nc), .fire_ack(fire_ack_nc), .bullet_count(bullet_count_nc)
  );

  typedef struct {
    int   x;
    int   y;
    logic exp;
  } pix_vec_t;

  pix_vec_t pix_tab[10];

  // Reference model of the main instance: one record per slot
  int m_act[4], m_bx[4], m_by[4], m_dir[4];
  int m_cd;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0; m_bx[i] = 0; m_by[i] = 0; m_dir[i] = 0;
    end
    m_cd = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; is_shooting = 1'b0; frame_clk = 1'b0;
    cyc(2);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic model_fire(input int x, input int y, input int d, output logic acc);
    int sx, sy, slot;
    sx = x + 23; sy = y + 23; slot = -1;
    for (int i = 3; i >= 0; i--) if (m_act[i] == 0) slot = i;
    acc = (m_cd == 0) && (slot >= 0) && (d == 1 || d == 2 || d == 3 || d == 4) &&
          (sx + 3 <= 639) && (sy + 3 <= 479);
    if (acc) begin
      m_act[slot] = 1; m_bx[slot] = sx; m_by[slot] = sy; m_dir[slot] = d; m_cd = 15;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 4; i++) begin
      if (m_act[i] != 0) begin
        case (m_dir[i])
          1: if (m_by[i] < 4) m_act[i] = 0; else m_by[i] -= 4;
          4: if (m_by[i] + 7 > 479) m_act[i] = 0; else m_by[i] += 4;
          3: if (m_bx[i] < 4) m_act[i] = 0; else m_bx[i] -= 4;
          2: if (m_bx[i] + 7 > 639) m_act[i] = 0; else m_bx[i] += 4;
          default: ;
        endcase
      end
    end
    if (m_cd > 0) m_cd--;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 4; i++) c += m_act[i];
    return c;
  endfunction

  function automatic logic model_pix(input int x, input int y);
    logic hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_act[i] != 0 && x >= m_bx[i] && x <= m_bx[i] + 3 && y >= m_by[i] && y <= m_by[i] + 3)
        hit = 1'b1;
    return hit;
  endfunction

  // One 1-cycle fire pulse; returns ack of both instances and the ack one cycle later
  task automatic fire(input int x, input int y, input int d,
                      output logic ack, output logic ack_nc, output logic ack_after);
    tank_X = 10'(x); tank_Y = 10'(y); tank_dir = 3'(d); is_shooting = 1'b1;
    cyc(1);
    is_shooting = 1'b0;
    ack = fire_ack; ack_nc = fire_ack_nc;
    cyc(1);
    ack_after = fire_ack;
  endtask

  // One frame strobe, long enough for the move to land; model follows
  task automatic do_tick();
    frame_clk = 1'b1; cyc(3);
    frame_clk = 1'b0; cyc(3);
    model_tick();
  endtask

  task automatic probe(input int x, input int y, output logic b, output logic b_nc);
    DrawX = 10'(x); DrawY = 10'(y);
    #1;
    b = is_bullet; b_nc = is_bullet_nc;
  endtask

  initial begin
    logic a, anc, aft, b, bnc, macc;
    int exp_y[5] = '{19, 15, 11, 7, 3};

    pix_tab[0] = '{523, 263, 1'b1};
    pix_tab[1] = '{526, 266, 1'b1};
    pix_tab[2] = '{524, 265, 1'b1};
    pix_tab[3] = '{526, 263, 1'b1};
    pix_tab[4] = '{527, 263, 1'b0};
    pix_tab[5] = '{523, 262, 1'b0};
    pix_tab[6] = '{522, 264, 1'b0};
    pix_tab[7] = '{525, 267, 1'b0};
    pix_tab[8] = '{0,   0,   1'b0};
    pix_tab[9] = '{523, 266, 1'b1};

    // Reset state
    do_reset();
    check("reset_count", bullet_count, 0);
    check("reset_ack", fire_ack, 0);
    probe(0, 0, b, bnc);
    check("reset_is_bullet_origin", b, 0);

    // Rejections with cooldown clear and pool empty
    fire(500, 240, 0, a, anc, aft);
    check("illegal_dir_ack", a, 0);
    check("illegal_dir_count", bullet_count, 0);
    fire(614, 240, 2, a, anc, aft);
    check("offscreen_x_ack", a, 0);
    fire(100, 454, 1, a, anc, aft);
    check("offscreen_y_ack", a, 0);

    // Right-moving bullet from (500,240): spawn, pixel table, flight, retire
    fire(500, 240, 2, a, anc, aft);
    check("fire_right_ack", a, 1);
    check("fire_right_ack_one_cycle", aft, 0);
    check("fire_right_count", bullet_count, 1);
    foreach (pix_tab[k]) begin
      probe(pix_tab[k].x, pix_tab[k].y, b, bnc);
      check($sformatf("pix_tab[%0d]", k), b, pix_tab[k].exp);
    end
    for (int t = 1; t <= 28; t++) do_tick();
    probe(635, 263, b, bnc); check("right_tick28_at_635", b, 1);
    probe(638, 266, b, bnc); check("right_tick28_far_corner", b, 1);
    probe(634, 263, b, bnc); check("right_tick28_left_of_box", b, 0);
    check("right_tick28_count", bullet_count, 1);
    do_tick();
    check("right_tick29_retired", bullet_count, 0);
    probe(635, 263, b, bnc); check("right_tick29_gone", b, 0);

    // Up-moving bullet from (100,0): spawn (123,23), retires on the 6th tick
    do_reset();
    fire(100, 0, 1, a, anc, aft);
    check("fire_up_ack", a, 1);
    probe(123, 23, b, bnc); check("up_spawn", b, 1);
    for (int t = 0; t < 5; t++) begin
      do_tick();
      probe(123, exp_y[t], b, bnc);
      check($sformatf("up_tick%0d_top", t + 1), b, 1);
      probe(123, exp_y[t] + 4, b, bnc);
      check($sformatf("up_tick%0d_below", t + 1), b, 0);
    end
    check("up_tick5_count", bullet_count, 1);
    do_tick();
    check("up_tick6_retired", bullet_count, 0);

    // Cooldown: rejected at 5 and 14 ticks, accepted at 15 into slot 1
    do_reset();
    fire(300, 200, 2, a, anc, aft);
    check("cd_first_ack", a, 1);
    for (int t = 0; t < 5; t++) do_tick();
    fire(300, 200, 2, a, anc, aft);
    check("cd_5ticks_ack", a, 0);
    check("cd_5ticks_count", bullet_count, 1);
    for (int t = 0; t < 9; t++) do_tick();
    fire(300, 200, 2, a, anc, aft);
    check("cd_14ticks_ack", a, 0);
    do_tick();
    fire(300, 200, 2, a, anc, aft);
    check("cd_15ticks_ack", a, 1);
    check("cd_15ticks_count", bullet_count, 2);
    probe(323, 223, b, bnc); check("cd_second_spawn", b, 1);
    probe(383, 223, b, bnc); check("cd_first_moved", b, 1);

    // Pool capacity on the no-cooldown instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fire(100, 100 + 8 * k, 1, a, anc, aft);
      check($sformatf("pool_fire%0d_ack", k), anc, (k < 4) ? 1 : 0);
    end
    check("pool_full_count", bullet_count_nc, 4);
    probe(123, 123 + 8 * 4, b, bnc); check("pool_rejected_not_drawn", bnc, 0);
    probe(123, 123 + 8 * 3, b, bnc); check("pool_slot3_drawn", bnc, 1);

    // Reset with live bullets clears everything on the same edge
    Reset = 1'b1; cyc(1); Reset = 1'b0; model_reset();
    check("midflight_reset_count_nc", bullet_count_nc, 0);
    probe(123, 123, b, bnc); check("midflight_reset_is_bullet_nc", bnc, 0);
    cyc(3);
    check("post_reset_no_tick_count", bullet_count_nc, 0);

    // Fire coincident with tick: spawn stays put, cooldown reloads to full
    do_reset();
    tank_X = 10'd500; tank_Y = 10'd240; tank_dir = 3'd2;
    frame_clk = 1'b1; cyc(2);
    is_shooting = 1'b1; cyc(1); is_shooting = 1'b0;
    check("coincident_ack", fire_ack, 1);
    model_fire(500, 240, 2, macc);
    cyc(2); frame_clk = 1'b0; cyc(3);
    probe(523, 263, b, bnc); check("coincident_at_spawn", b, 1);
    probe(527, 263, b, bnc); check("coincident_not_moved", b, 0);
    do_tick();
    probe(527, 263, b, bnc); check("coincident_moved_next_tick", b, 1);
    probe(526, 263, b, bnc); check("coincident_left_behind", b, 0);
    for (int t = 0; t < 13; t++) do_tick();
    fire(100, 100, 1, a, anc, aft);
    check("coincident_cd_reload_14ticks", a, 0);
    model_fire(100, 100, 1, macc);

    // Random fire/tick traffic against the model
    do_reset();
    for (int op = 0; op < 300; op++) begin
      if ($urandom_range(0, 9) < 6) begin
        do_tick();
      end else begin
        int x, y, d;
        x = int'($urandom_range(0, 660));
        y = int'($urandom_range(0, 500));
        d = int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) d = int'($urandom_range(1, 4));
        fire(x, y, d, a, anc, aft);
        model_fire(x, y, d, macc);
        check("rand_ack", a, macc);
      end
      check("rand_count", bullet_count, model_count());
      for (int p = 0; p < 3; p++) begin
        int j, px, py;
        j = int'($urandom_range(0, 3));
        if (m_act[j] != 0 && $urandom_range(0, 2) != 0) begin
          px = m_bx[j] + int'($urandom_range(0, 5)) - 1;
          py = m_by[j] + int'($urandom_range(0, 5)) - 1;
        end else begin
          px = int'($urandom_range(0, 639));
          py = int'($urandom_range(0, 479));
        end
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        probe(px, py, b, bnc);
        check($sformatf("rand_pix(%0d,%0d)", px, py), b, model_pix(px, py));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
